// File: rtl/cache_line_store_pkg.sv
// Shared types and default geometry for the cache line store.
// Holds the fill FSM state encoding and a way-width helper.
package cache_line_store_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int WAYS_DEF   = 2;
    localparam int SETS_DEF   = 64;
    localparam int WORDS_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_e;

    // A single-way store still carries a 1-bit way select.
    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_line_store_if.sv
// Word write, read and line fill bus of the cache line store.
// master drives requests and fill words, slave is the store.
interface cache_line_store_if
    import cache_line_store_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WAYS   = WAYS_DEF,
    parameter int SETS   = SETS_DEF,
    parameter int WORDS  = WORDS_DEF
);
    localparam int WAY_W = way_width(WAYS);
    localparam int IDX_W = $clog2(SETS);
    localparam int OFS_W = $clog2(WORDS);

    logic                   wr_en;
    logic [WAY_W-1:0]       wr_way;
    logic [IDX_W-1:0]       wr_index;
    logic [OFS_W-1:0]       wr_offset;
    logic [DATA_W-1:0]      wr_data;
    logic                   rd_en;
    logic [IDX_W-1:0]       rd_index;
    logic [OFS_W-1:0]       rd_offset;
    logic [WAYS*DATA_W-1:0] rd_data;
    logic                   rd_valid;
    logic                   fill_start;
    logic [WAY_W-1:0]       fill_way;
    logic [IDX_W-1:0]       fill_index;
    logic                   fill_valid;
    logic [DATA_W-1:0]      fill_data;
    logic                   fill_ready;
    logic                   busy;
    logic                   fill_done;

    modport master (
        output wr_en, wr_way, wr_index, wr_offset, wr_data,
        output rd_en, rd_index, rd_offset,
        output fill_start, fill_way, fill_index,
        output fill_valid, fill_data,
        input  rd_data, rd_valid, fill_ready, busy, fill_done
    );

    modport slave (
        input  wr_en, wr_way, wr_index, wr_offset, wr_data,
        input  rd_en, rd_index, rd_offset,
        input  fill_start, fill_way, fill_index,
        input  fill_valid, fill_data,
        output rd_data, rd_valid, fill_ready, busy, fill_done
    );

endinterface

// File: rtl/cache_way_bank.sv
// One way of the store: SETS x WORDS words, one write port
// and one registered read word (read returns pre-write data).
module cache_way_bank #(
    parameter int DATA_W = 16,
    parameter int SETS   = 64,
    parameter int WORDS  = 8,
    parameter int IDX_W  = $clog2(SETS),
    parameter int OFS_W  = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  w_index,
    input  logic [OFS_W-1:0]  w_offset,
    input  logic [DATA_W-1:0] w_data,
    input  logic              re,
    input  logic [IDX_W-1:0]  r_index,
    input  logic [OFS_W-1:0]  r_offset,
    output logic [DATA_W-1:0] r_data
);
    localparam int DEPTH = SETS * WORDS;

    logic [DATA_W-1:0] mem [DEPTH];

    // Word storage, cleared as a whole on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[{w_index, w_offset}] <= w_data;
        end
    end

    // Read register; holds its value when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (re) begin
            r_data <= mem[{r_index, r_offset}];
        end
    end

endmodule

// File: rtl/cache_line_store.sv
// Multi-way line store with single-word writes, all-way reads
// and a handshaked whole-line fill sequenced by a small FSM.
module cache_line_store
    import cache_line_store_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WAYS   = WAYS_DEF,
    parameter int SETS   = SETS_DEF,
    parameter int WORDS  = WORDS_DEF
) (
    input logic         clk,
    input logic         rst,
    cache_line_store_if.slave bus
);
    localparam int WAY_W = way_width(WAYS);
    localparam int IDX_W = $clog2(SETS);
    localparam int OFS_W = $clog2(WORDS);

    fill_state_e       state;
    fill_state_e       next;
    logic [WAY_W-1:0]  lat_way;
    logic [IDX_W-1:0]  lat_index;
    logic [OFS_W-1:0]  count;
    logic              accept;

    logic [WAYS-1:0]   bank_we;
    logic [IDX_W-1:0]  w_index;
    logic [OFS_W-1:0]  w_offset;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] way_rd [WAYS];

    assign accept = (state == FILL) && bus.fill_valid;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        next           = state;
        bus.fill_ready = 1'b0;
        bus.busy       = 1'b0;
        bus.fill_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.fill_start) begin
                    next = FILL;
                end
            end
            FILL: begin
                bus.fill_ready = 1'b1;
                bus.busy       = 1'b1;
                if (accept && count == OFS_W'(WORDS - 1)) begin
                    next = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.fill_done = 1'b1;
                next          = IDLE;
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    // Latch the target line at fill start and count accepted words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_way   <= '0;
            lat_index <= '0;
            count     <= '0;
        end else if (state == IDLE && bus.fill_start) begin
            lat_way   <= bus.fill_way;
            lat_index <= bus.fill_index;
            count     <= '0;
        end else if (accept) begin
            count <= count + 1'b1;
        end
    end

    // Steer fill words or idle word writes to one bank; writes
    // arriving while a fill is in progress are dropped.
    always_comb begin
        bank_we  = '0;
        w_index  = bus.wr_index;
        w_offset = bus.wr_offset;
        w_data   = bus.wr_data;
        if (accept) begin
            w_index  = lat_index;
            w_offset = count;
            w_data   = bus.fill_data;
            for (int w = 0; w < WAYS; w++) begin
                bank_we[w] = (lat_way == WAY_W'(w));
            end
        end else if (state == IDLE && bus.wr_en) begin
            for (int w = 0; w < WAYS; w++) begin
                bank_we[w] = (bus.wr_way == WAY_W'(w));
            end
        end
    end

    // Read strobe mirrors each read request into rd_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_bank #(
            .DATA_W (DATA_W),
            .SETS   (SETS),
            .WORDS  (WORDS)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .we       (bank_we[w]),
            .w_index  (w_index),
            .w_offset (w_offset),
            .w_data   (w_data),
            .re       (bus.rd_en),
            .r_index  (bus.rd_index),
            .r_offset (bus.rd_offset),
            .r_data   (way_rd[w])
        );
        assign bus.rd_data[w*DATA_W +: DATA_W] = way_rd[w];
    end

endmodule

// File: tb/tb_cache_line_store.sv
// Bench for cache_line_store: directed stimulus, a behavioural
// model checked every cycle, plus literal spot checks.
module tb_cache_line_store;
    localparam int DATA_W = 16;
    localparam int WAYS   = 2;
    localparam int SETS   = 64;
    localparam int WORDS  = 8;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;
    int done_count = 0;

    cache_line_store_if #(
        .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)
    ) bus ();

    cache_line_store #(
        .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: plain arrays and a fill progress record.
    logic [DATA_W-1:0]      mem [WAYS][SETS][WORDS];
    logic [WAYS*DATA_W-1:0] exp_rd;
    logic                   exp_valid;
    bit                     m_filling;
    bit                     m_done;
    int                     m_cnt;
    int                     m_way;
    int                     m_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++)
                    for (int o = 0; o < WORDS; o++)
                        mem[w][s][o] <= '0;
            exp_rd    <= '0;
            exp_valid <= 1'b0;
            m_filling <= 1'b0;
            m_done    <= 1'b0;
            m_cnt     <= 0;
            m_way     <= 0;
            m_idx     <= 0;
        end else begin
            exp_valid <= bus.rd_en;
            if (bus.rd_en) begin
                for (int w = 0; w < WAYS; w++)
                    exp_rd[w*DATA_W +: DATA_W] <=
                        mem[w][bus.rd_index][bus.rd_offset];
            end
            if (m_done) begin
                m_done <= 1'b0;
            end else if (m_filling) begin
                if (bus.fill_valid) begin
                    mem[m_way][m_idx][m_cnt] <= bus.fill_data;
                    if (m_cnt == WORDS - 1) begin
                        m_cnt     <= 0;
                        m_filling <= 1'b0;
                        m_done    <= 1'b1;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
            end else begin
                if (bus.wr_en)
                    mem[bus.wr_way][bus.wr_index][bus.wr_offset]
                        <= bus.wr_data;
                if (bus.fill_start) begin
                    m_filling <= 1'b1;
                    m_cnt     <= 0;
                    m_way     <= int'(bus.fill_way);
                    m_idx     <= int'(bus.fill_index);
                end
            end
        end
    end

    task automatic check(input string name,
                         input logic [63:0] got,
                         input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, got, want, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("m_rd_valid", 64'(bus.rd_valid), 64'(exp_valid));
            check("m_rd_data", 64'(bus.rd_data), 64'(exp_rd));
            check("m_fill_ready", 64'(bus.fill_ready),
                  64'(m_filling));
            check("m_busy", 64'(bus.busy),
                  64'(m_filling | m_done));
            check("m_fill_done", 64'(bus.fill_done), 64'(m_done));
            if (bus.fill_done) done_count++;
        end
    end

    task automatic clr();
        bus.wr_en      = 1'b0;
        bus.wr_way     = '0;
        bus.wr_index   = '0;
        bus.wr_offset  = '0;
        bus.wr_data    = '0;
        bus.rd_en      = 1'b0;
        bus.rd_index   = '0;
        bus.rd_offset  = '0;
        bus.fill_start = 1'b0;
        bus.fill_way   = '0;
        bus.fill_index = '0;
        bus.fill_valid = 1'b0;
        bus.fill_data  = '0;
    endtask

    task automatic step();
        @(negedge clk);
        clr();
    endtask

    task automatic write_word(input int way, input int idx,
                              input int ofs, input int data);
        step();
        bus.wr_en     = 1'b1;
        bus.wr_way    = 1'(way);
        bus.wr_index  = 6'(idx);
        bus.wr_offset = 3'(ofs);
        bus.wr_data   = 16'(data);
    endtask

    task automatic read_word(input int idx, input int ofs);
        step();
        bus.rd_en     = 1'b1;
        bus.rd_index  = 6'(idx);
        bus.rd_offset = 3'(ofs);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        logic [31:0] want;
        clr();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_fill_ready", 64'(bus.fill_ready), 64'd0);
        check("rst_fill_done", 64'(bus.fill_done), 64'd0);
        check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);

        read_word(0, 0);
        check("rd00_valid", 64'(bus.rd_valid), 64'd1);
        check("rd00_data", 64'(bus.rd_data), 64'd0);
        step();
        check("rd_valid_drop", 64'(bus.rd_valid), 64'd0);

        write_word(1, 5, 3, 16'hBEEF);
        read_word(5, 3);
        check("rd53_beef", 64'(bus.rd_data), 64'h0000_0000_BEEF_0000);
        read_word(4, 3);
        check("rd43_zero", 64'(bus.rd_data), 64'd0);

        // Fill way0 idx63 while a way1 word write lands the same cycle.
        step();
        bus.fill_start = 1'b1;
        bus.fill_way   = 1'b0;
        bus.fill_index = 6'd63;
        bus.wr_en      = 1'b1;
        bus.wr_way     = 1'b1;
        bus.wr_index   = 6'd63;
        bus.wr_offset  = 3'd7;
        bus.wr_data    = 16'h7777;
        step();
        check("fill_busy", 64'(bus.busy), 64'd1);
        check("fill_ready", 64'(bus.fill_ready), 64'd1);
        dc = done_count;
        for (int k = 0; k < WORDS; k++) begin
            repeat (2) begin
                step();
                bus.rd_en     = 1'b1;
                bus.rd_index  = 6'd5;
                bus.rd_offset = 3'd3;
                if (k == 3) begin
                    bus.wr_en      = 1'b1;
                    bus.wr_way     = 1'b0;
                    bus.wr_index   = 6'd63;
                    bus.wr_offset  = 3'd2;
                    bus.wr_data    = 16'hDEAD;
                    bus.fill_start = 1'b1;
                    bus.fill_way   = 1'b1;
                end
            end
            step();
            bus.fill_valid = 1'b1;
            bus.fill_data  = 16'(16'h1000 + k);
        end
        step();
        check("fill_done_pulse", 64'(bus.fill_done), 64'd1);
        step();
        check("fill_idle_busy", 64'(bus.busy), 64'd0);
        step();
        check("fill_done_once", 64'(done_count - dc), 64'd1);
        for (int k = 0; k < WORDS; k++) begin
            read_word(63, k);
            want = {16'h0000, 16'(16'h1000 + k)};
            if (k == 7) want = {16'h7777, 16'h1007};
            check($sformatf("fill_ofs%0d", k), 64'(bus.rd_data),
                  64'(want));
        end

        // Read and write the same word in one cycle.
        write_word(0, 7, 0, 16'h1111);
        step();
        bus.rd_en     = 1'b1;
        bus.rd_index  = 6'd7;
        bus.rd_offset = 3'd0;
        bus.wr_en     = 1'b1;
        bus.wr_way    = 1'b0;
        bus.wr_index  = 6'd7;
        bus.wr_offset = 3'd0;
        bus.wr_data   = 16'h2222;
        step();
        check("rw_old", 64'(bus.rd_data[15:0]), 64'h1111);
        read_word(7, 0);
        check("rw_new", 64'(bus.rd_data[15:0]), 64'h2222);

        // Reset after three fill words aborts the fill.
        step();
        bus.fill_start = 1'b1;
        bus.fill_way   = 1'b0;
        bus.fill_index = 6'd63;
        for (int k = 0; k < 3; k++) begin
            step();
            bus.fill_valid = 1'b1;
            bus.fill_data  = 16'(16'hA000 + k);
        end
        step();
        dc = done_count;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_ready", 64'(bus.fill_ready), 64'd0);
        check("abort_rd_data", 64'(bus.rd_data), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (WORDS + 2) step();
        check("abort_no_done", 64'(done_count - dc), 64'd0);
        for (int k = 0; k < WORDS; k++) begin
            read_word(63, k);
            check($sformatf("abort_ofs%0d", k), 64'(bus.rd_data),
                  64'd0);
        end
        read_word(5, 3);
        check("abort_clr53", 64'(bus.rd_data), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
